// File: rtl/data_island_scheduler.sv
// -----------------------------------------------------------------------------
// data_island_scheduler
//
// Places HDMI data-island periods into the blanking regions of one pixel
// stream. Each island is: 8 preamble pixels, 2 leading guard pixels, one or
// more back-to-back 32-pixel packets, and 2 trailing guard pixels. An island
// only starts after a minimum run of control pixels, only when the packet
// picker has something to send, and only if it fits before the end of the
// line with the slack needed by the following video preamble/guard.
//
// Every output is registered: the values present in cycle n+1 describe the
// pixel (cx, cy, packet_request) sampled at the clock edge of cycle n.
//
// Ports
//   clk_pixel             in   pixel clock
//   reset_n               in   asynchronous active-low reset
//   cx, cy                in   current raster position
//   packet_request        in   picker has a non-null packet pending
//   island_preamble       out  island preamble pixel
//   island_guard          out  island guard-band pixel (leading or trailing)
//   island_data           out  packet payload pixel
//   packet_enable         out  one-pixel pulse: picker latches next packet
//   packet_pixel_counter  out  0..31 inside a packet, 0 elsewhere
//   video_field_end       out  pulse at the last active pixel of the field
//   schedule_error        out  sticky: an island was cut short by active video
// -----------------------------------------------------------------------------
module data_island_scheduler #(
    parameter int BIT_WIDTH     = 10,
    parameter int BIT_HEIGHT    = 10,
    parameter int FRAME_WIDTH   = 800,
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int MAX_PACKETS   = 18,
    parameter int MIN_CONTROL   = 12
) (
    input  logic                  clk_pixel,
    input  logic                  reset_n,
    input  logic [BIT_WIDTH-1:0]  cx,
    input  logic [BIT_HEIGHT-1:0] cy,
    input  logic                  packet_request,
    output logic                  island_preamble,
    output logic                  island_guard,
    output logic                  island_data,
    output logic                  packet_enable,
    output logic [4:0]            packet_pixel_counter,
    output logic                  video_field_end,
    output logic                  schedule_error
);

    // Island footprint: 8 preamble + 2 guard + 32 data + 2 guard, plus 22
    // pixels kept free for the next line's control/video preamble/guard.
    localparam int START_ROOM    = 66;
    // Room needed after the current packet to fit another packet, the
    // trailing guard and the same 22-pixel slack.
    localparam int CONTINUE_ROOM = 56;

    localparam int RUN_W = $clog2(MIN_CONTROL + 1);
    localparam int PKT_W = $clog2(MAX_PACKETS + 1);

    localparam logic [RUN_W-1:0] RUN_MIN = RUN_W'(MIN_CONTROL);
    localparam logic [PKT_W-1:0] PKT_MAX = PKT_W'(MAX_PACKETS);

    typedef enum logic [2:0] {
        S_CTL,
        S_PREAMBLE,
        S_GUARD_LEAD,
        S_DATA,
        S_GUARD_TRAIL
    } state_t;

    // state_reg/phase_reg describe the pixel that will be sampled next
    // (phase_reg is the index of that pixel inside its period).
    state_t           state_reg;
    logic [4:0]       phase_reg;
    logic [RUN_W-1:0] ctl_run_reg;
    logic [PKT_W-1:0] pkt_count_reg;

    logic [31:0]      cx_ext;
    logic [31:0]      cy_ext;
    logic             active_pixel;
    logic             field_end_pixel;
    logic [RUN_W-1:0] ctl_run_eff;
    logic             run_ok;
    logic             start_ok;
    logic             continue_ok;

    assign cx_ext = 32'(cx);
    assign cy_ext = 32'(cy);

    assign active_pixel    = (cx_ext < 32'(SCREEN_WIDTH)) && (cy_ext < 32'(SCREEN_HEIGHT));
    assign field_end_pixel = (cx_ext == 32'(SCREEN_WIDTH - 1)) && (cy_ext == 32'(SCREEN_HEIGHT - 1));

    // The control run restarts at the beginning of every line, so even in
    // vertical blanking an island never starts right at cx = 0.
    assign ctl_run_eff = (cx_ext == 32'd0) ? '0 : ctl_run_reg;
    assign run_ok      = (ctl_run_eff >= RUN_MIN);

    assign start_ok    = run_ok && packet_request
                         && (cx_ext + 32'(START_ROOM) <= 32'(FRAME_WIDTH));

    assign continue_ok = packet_request && (pkt_count_reg < PKT_MAX)
                         && (cx_ext + 32'd1 + 32'(CONTINUE_ROOM) <= 32'(FRAME_WIDTH));

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            state_reg            <= S_CTL;
            phase_reg            <= '0;
            ctl_run_reg          <= '0;
            pkt_count_reg        <= '0;
            island_preamble      <= 1'b0;
            island_guard         <= 1'b0;
            island_data          <= 1'b0;
            packet_enable        <= 1'b0;
            packet_pixel_counter <= '0;
            video_field_end      <= 1'b0;
            schedule_error       <= 1'b0;
        end else begin
            island_preamble      <= 1'b0;
            island_guard         <= 1'b0;
            island_data          <= 1'b0;
            packet_enable        <= 1'b0;
            packet_pixel_counter <= '0;
            video_field_end      <= field_end_pixel;

            if (active_pixel) begin
                // Active video always wins; an island still in flight is
                // dropped on the spot and the fault is remembered.
                if (state_reg != S_CTL) begin
                    schedule_error <= 1'b1;
                end
                state_reg     <= S_CTL;
                phase_reg     <= '0;
                ctl_run_reg   <= '0;
                pkt_count_reg <= '0;
            end else begin
                case (state_reg)
                    S_CTL: begin
                        if (start_ok) begin
                            // This pixel is preamble 0; the first packet is
                            // committed from here on.
                            island_preamble <= 1'b1;
                            state_reg       <= S_PREAMBLE;
                            phase_reg       <= 5'd1;
                            ctl_run_reg     <= '0;
                            pkt_count_reg   <= PKT_W'(1);
                        end else begin
                            ctl_run_reg <= run_ok ? RUN_MIN : ctl_run_eff + RUN_W'(1);
                        end
                    end

                    S_PREAMBLE: begin
                        island_preamble <= 1'b1;
                        if (phase_reg == 5'd7) begin
                            state_reg <= S_GUARD_LEAD;
                            phase_reg <= '0;
                        end else begin
                            phase_reg <= phase_reg + 5'd1;
                        end
                    end

                    S_GUARD_LEAD: begin
                        island_guard <= 1'b1;
                        if (phase_reg == 5'd1) begin
                            packet_enable <= 1'b1;
                            state_reg     <= S_DATA;
                            phase_reg     <= '0;
                        end else begin
                            phase_reg <= phase_reg + 5'd1;
                        end
                    end

                    S_DATA: begin
                        island_data          <= 1'b1;
                        packet_pixel_counter <= phase_reg;
                        if (phase_reg == 5'd31) begin
                            phase_reg <= '0;
                            if (continue_ok) begin
                                packet_enable <= 1'b1;
                                pkt_count_reg <= pkt_count_reg + PKT_W'(1);
                            end else begin
                                state_reg <= S_GUARD_TRAIL;
                            end
                        end else begin
                            phase_reg <= phase_reg + 5'd1;
                        end
                    end

                    S_GUARD_TRAIL: begin
                        island_guard <= 1'b1;
                        if (phase_reg == 5'd1) begin
                            state_reg     <= S_CTL;
                            phase_reg     <= '0;
                            ctl_run_reg   <= '0;
                            pkt_count_reg <= '0;
                        end else begin
                            phase_reg <= phase_reg + 5'd1;
                        end
                    end

                    default: begin
                        state_reg     <= S_CTL;
                        phase_reg     <= '0;
                        ctl_run_reg   <= '0;
                        pkt_count_reg <= '0;
                    end
                endcase
            end
        end
    end

endmodule
